// File: rtl/program_ram_pkg.sv
// Shared types and constants for the program RAM: FSM state encoding,
// default geometry and the NOP instruction word.
package program_ram_pkg;

   localparam int DATA_W_DEF = 14;
   localparam int ADDR_W_DEF = 11;

   localparam logic [DATA_W_DEF-1:0] NOP = '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic state_busy(input state_e s);
      return (s == ST_LOAD) || (s == ST_DONE);
   endfunction

endpackage

// File: rtl/program_ram_mem_array.sv
// DEPTH x DATA_W instruction storage with one synchronous write port and one
// synchronous read port. Contents are never touched by reset.
module prog_mem_array #(
   parameter int DATA_W = 14,
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   // Power-up contents are the all-zero NOP word from the device's memory
   // initialisation; no reset path exists so the array maps onto block RAM.
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      // Read register only updates on a request, so the last word is held.
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/program_ram.sv
// Program RAM controller: burst loader FSM with down-counting word count,
// plus a single-cycle-latency fetch port that yields to loads.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | fetches served; Load_start_in begins a burst
//   LOAD    | Load_ready_out high; each accepted word written, addr+1
//   DONE    | Done_out pulse for one cycle, then back to IDLE
module program_ram
   import program_ram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Fetch_en_in,
   input  logic [ADDR_W-1:0] Fetch_addr_in,
   output logic [DATA_W-1:0] Fetch_data_out,
   output logic              Fetch_valid_out,
   input  logic              Load_start_in,
   input  logic [ADDR_W-1:0] Load_base_in,
   input  logic [LEN_W-1:0]  Load_len_in,
   input  logic              Load_valid_in,
   input  logic [DATA_W-1:0] Load_data_in,
   output logic              Load_ready_out,
   output logic              Busy_out,
   output logic              Done_out
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic                fetch_valid_q, fetch_valid_d;
   logic                fetch_blank_q, fetch_blank_d;

   logic                fetch_go;
   logic                wr_en;
   logic [DATA_W-1:0]   rd_data;

   assign fetch_go = (state_q == ST_IDLE) && Fetch_en_in && !Load_start_in;

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      cnt_d         = cnt_q;
      wr_en         = 1'b0;
      fetch_valid_d = fetch_go;
      fetch_blank_d = fetch_blank_q && !fetch_go;

      case (state_q)
         ST_IDLE: begin
            if (Load_start_in) begin
               if (Load_len_in != '0) begin
                  addr_d  = Load_base_in;
                  cnt_d   = Load_len_in;
                  state_d = ST_LOAD;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_LOAD: begin
            if (Load_valid_in) begin
               wr_en  = 1'b1;
               addr_d = addr_q + ADDR_W'(1);
               cnt_d  = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         cnt_q         <= '0;
         fetch_valid_q <= 1'b0;
         fetch_blank_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         cnt_q         <= cnt_d;
         fetch_valid_q <= fetch_valid_d;
         fetch_blank_q <= fetch_blank_d;
      end
   end

   prog_mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (addr_q),
      .wr_data_i (Load_data_in),
      .rd_en_i   (fetch_go),
      .rd_addr_i (Fetch_addr_in),
      .rd_data_o (rd_data)
   );

   // The RAM read register has no reset; blank it until the first fetch
   // after reset so the output reads NOP asynchronously on reset.
   assign Fetch_data_out  = fetch_blank_q ? DATA_W'(NOP) : rd_data;
   assign Fetch_valid_out = fetch_valid_q;
   assign Load_ready_out  = (state_q == ST_LOAD);
   assign Busy_out        = state_busy(state_q);
   assign Done_out        = (state_q == ST_DONE);

endmodule

// File: tb/tb_program_ram.sv
// Randomised scoreboard bench for program_ram: the driver updates a plain
// array model of memory and queues expected fetch results; a monitor checks.
module tb_program_ram;

   localparam int DW    = 14;
   localparam int AW    = 11;
   localparam int LW    = 12;
   localparam int DEPTH = 2048;

   logic          clk = 1'b0;
   logic          reset;
   logic          Fetch_en_in;
   logic [AW-1:0] Fetch_addr_in;
   logic [DW-1:0] Fetch_data_out;
   logic          Fetch_valid_out;
   logic          Load_start_in;
   logic [AW-1:0] Load_base_in;
   logic [LW-1:0] Load_len_in;
   logic          Load_valid_in;
   logic [DW-1:0] Load_data_in;
   logic          Load_ready_out;
   logic          Busy_out;
   logic          Done_out;

   program_ram dut (
      .clk             (clk),
      .reset           (reset),
      .Fetch_en_in     (Fetch_en_in),
      .Fetch_addr_in   (Fetch_addr_in),
      .Fetch_data_out  (Fetch_data_out),
      .Fetch_valid_out (Fetch_valid_out),
      .Load_start_in   (Load_start_in),
      .Load_base_in    (Load_base_in),
      .Load_len_in     (Load_len_in),
      .Load_valid_in   (Load_valid_in),
      .Load_data_in    (Load_data_in),
      .Load_ready_out  (Load_ready_out),
      .Busy_out        (Busy_out),
      .Done_out        (Done_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      logic [DW-1:0] data;
   } exp_t;

   logic [DW-1:0] model_mem [DEPTH];
   exp_t          exp_q[$];
   logic [AW-1:0] hot[$];
   int            cyc = 0;
   int            n_total = 0;
   int            n_pass = 0;
   int            done_cnt = 0;
   logic [DW-1:0] hold_exp = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: pops the expected word whenever a fetch result is due.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (Done_out === 1'b1) done_cnt++;
         if (reset) begin
            hold_exp = '0;
         end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               e = exp_q.pop_front();
               chk("fetch_missing", 32'd0, 32'd1);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
               e = exp_q.pop_front();
               chk("fetch_valid", {31'd0, Fetch_valid_out}, 32'd1);
               chk("fetch_data", {18'd0, Fetch_data_out}, {18'd0, e.data});
               hold_exp = e.data;
            end else begin
               chk("fetch_valid_idle", {31'd0, Fetch_valid_out}, 32'd0);
               chk("fetch_data_hold", {18'd0, Fetch_data_out}, {18'd0, hold_exp});
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] base, input int off);
      return AW'((int'(base) + off) % DEPTH);
   endfunction

   task automatic push_fetch(input logic [AW-1:0] a);
      exp_t e;
      e.cyc  = cyc + 1;
      e.data = model_mem[a];
      exp_q.push_back(e);
   endtask

   task automatic fetch_seq(input logic [AW-1:0] addrs[$]);
      foreach (addrs[i]) begin
         Fetch_en_in   = 1'b1;
         Fetch_addr_in = addrs[i];
         push_fetch(addrs[i]);
         @(posedge clk); #1;
      end
      Fetch_en_in = 1'b0;
   endtask

   task automatic fetch_rand(input int n);
      repeat (n) begin
         Fetch_en_in = 1'($urandom_range(0, 1));
         if (hot.size() > 0 && $urandom_range(0, 1) == 1)
            Fetch_addr_in = hot[$urandom_range(0, hot.size() - 1)];
         else
            Fetch_addr_in = AW'($urandom);
         if (Fetch_en_in) push_fetch(Fetch_addr_in);
         @(posedge clk); #1;
      end
      Fetch_en_in = 1'b0;
   endtask

   // gap: 0 random valid, 1 valid every other cycle, 2 valid every cycle
   task automatic load_burst(input logic [AW-1:0] base, input int len, input int gap,
                             input bit hold_fetch, input logic [DW-1:0] words[$]);
      int            d0;
      int            acc;
      int            guard;
      logic          v;
      logic [AW-1:0] fa;
      d0    = done_cnt;
      acc   = 0;
      guard = 0;
      fa    = AW'($urandom);
      Load_start_in = 1'b1;
      Load_base_in  = base;
      Load_len_in   = LW'(len);
      Fetch_en_in   = hold_fetch ? 1'b1 : 1'($urandom_range(0, 1));
      Fetch_addr_in = fa;
      @(posedge clk); #1;
      Load_start_in = 1'b0;
      while (acc < len && guard < 400) begin
         chk("ready_in_load", {31'd0, Load_ready_out}, 32'd1);
         chk("busy_in_load", {31'd0, Busy_out}, 32'd1);
         v = (gap == 1) ? 1'(guard % 2) : (gap == 2) ? 1'b1 : 1'($urandom_range(0, 1));
         Load_valid_in = v;
         Load_data_in  = v ? words[acc] : DW'($urandom);
         Load_start_in = ($urandom_range(0, 3) == 0);
         Load_base_in  = AW'($urandom);
         Load_len_in   = LW'($urandom_range(1, 9));
         Fetch_en_in   = hold_fetch ? 1'b1 : 1'($urandom_range(0, 1));
         if (v) begin
            model_mem[wrap_addr(base, acc)] = words[acc];
            hot.push_back(wrap_addr(base, acc));
            acc++;
         end
         guard++;
         @(posedge clk); #1;
      end
      Load_valid_in = 1'b0;
      Load_start_in = 1'b0;
      if (guard >= 400) chk("load_timeout", 32'd0, 32'd1);
      chk("done_pulse", {31'd0, Done_out}, 32'd1);
      chk("busy_in_done", {31'd0, Busy_out}, 32'd1);
      chk("ready_in_done", {31'd0, Load_ready_out}, 32'd0);
      @(posedge clk); #1;
      chk("done_clear", {31'd0, Done_out}, 32'd0);
      chk("busy_clear", {31'd0, Busy_out}, 32'd0);
      chk("done_count", 32'(done_cnt - d0), 32'd1);
      if (hold_fetch) begin
         push_fetch(fa);
         @(posedge clk); #1;
      end
      Fetch_en_in = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, {31'd0, Busy_out}, 32'd0);
      chk({tag, "_ready"}, {31'd0, Load_ready_out}, 32'd0);
      chk({tag, "_done"}, {31'd0, Done_out}, 32'd0);
      chk({tag, "_valid"}, {31'd0, Fetch_valid_out}, 32'd0);
      chk({tag, "_data"}, {18'd0, Fetch_data_out}, 32'd0);
   endtask

   initial begin
      logic [DW-1:0] w[$];
      logic [AW-1:0] a[$];
      logic [AW-1:0] rb;
      int            d0;
      int            len;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      reset = 1'b1;
      Fetch_en_in = 1'b0; Fetch_addr_in = '0;
      Load_start_in = 1'b0; Load_base_in = '0; Load_len_in = '0;
      Load_valid_in = 1'b0; Load_data_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      // Unloaded location reads NOP
      a = '{11'h005};
      fetch_seq(a);

      // Gapped six-word load, then read back
      w = '{14'h01A5, 14'h0103, 14'h3007, 14'h07A5, 14'h0725, 14'h2805};
      load_burst(11'h000, 6, 1, 1'b0, w);
      a = '{11'h000, 11'h001, 11'h002, 11'h003, 11'h004, 11'h005};
      fetch_seq(a);

      // Address wrap at top of memory
      w = '{14'h3400, 14'h3401, 14'h3402};
      load_burst(11'h7FE, 3, 2, 1'b0, w);
      a = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
      fetch_seq(a);

      // Zero-length load: immediate DONE, nothing written
      w = '{};
      load_burst(11'h001, 0, 2, 1'b0, w);
      a = '{11'h001, 11'h002};
      fetch_seq(a);

      // Fetch held high across a two-word load is dropped
      w = '{14'h1111, 14'h2222};
      load_burst(11'h100, 2, 0, 1'b1, w);
      a = '{11'h100, 11'h101};
      fetch_seq(a);

      // Reset after two of four words
      d0 = done_cnt;
      Load_start_in = 1'b1; Load_base_in = 11'h002; Load_len_in = 12'd4;
      @(posedge clk); #1;
      Load_start_in = 1'b0;
      for (int i = 0; i < 2; i++) begin
         Load_valid_in = 1'b1;
         Load_data_in  = 14'h0AA0 + DW'(i);
         model_mem[11'h002 + AW'(i)] = 14'h0AA0 + DW'(i);
         @(posedge clk); #1;
      end
      Load_valid_in = 1'b1;
      Load_data_in  = 14'h3FFF;
      #2;
      reset = 1'b1;
      #1;
      chk_all_zero("async_reset");
      Load_valid_in = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_no_done", 32'(done_cnt - d0), 32'd0);
      chk("reset_idle_busy", {31'd0, Busy_out}, 32'd0);
      a = '{11'h002, 11'h003, 11'h004, 11'h005};
      fetch_seq(a);

      // Randomised mix of loads and fetches
      repeat (40) begin
         if ($urandom_range(0, 1) == 1) begin
            fetch_rand($urandom_range(2, 10));
         end else begin
            len = $urandom_range(0, 8);
            rb  = AW'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 11'h7FC;
            w = '{};
            for (int i = 0; i < len; i++) w.push_back(DW'($urandom));
            load_burst(rb, len, $urandom_range(0, 2), 1'($urandom_range(0, 1)), w);
         end
      end
      fetch_rand(20);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
